// File: rtl/message_sequencer_if.sv
// Handshake bundle between the frame timing/control side and the message sequencer.
// The master drives line count and control, the slave returns renderer controls.
interface message_sequencer_if;
  logic [10:0] vcnt;
  logic        start;
  logic        enable;
  logic [7:0]  display_length;
  logic        str_en;
  logic        cursor_on;
  logic        done;

  modport master (
    output vcnt, start, enable,
    input  display_length, str_en, cursor_on, done
  );

  modport slave (
    input  vcnt, start, enable,
    output display_length, str_en, cursor_on, done
  );
endinterface

// File: rtl/message_sequencer.sv
// Typewriter-style message reveal: one character every CHAR_FRAMES frames, then a
// blinking-cursor hold, then either loop or keep the full message on screen.
module message_sequencer #(
  parameter int LENGTH       = 12,
  parameter int V_VISIBLE    = 480,
  parameter int CHAR_FRAMES  = 15,
  parameter int HOLD_FRAMES  = 180,
  parameter int LOOP         = 1,
  parameter int BLINK_FRAMES = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  message_sequencer_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, TYPE, HOLD, SHOW} state_t;

  localparam logic [10:0] V_LINE     = 11'(V_VISIBLE);
  localparam logic [7:0]  LEN_LAST   = 8'(LENGTH);
  localparam logic [9:0]  CHAR_LAST  = 10'(CHAR_FRAMES - 1);
  localparam logic [9:0]  HOLD_LAST  = 10'(HOLD_FRAMES - 1);
  localparam logic [9:0]  BLINK_LAST = 10'(BLINK_FRAMES - 1);

  state_t      state;
  logic [9:0]  fcnt;
  logic [9:0]  bcnt;
  logic [7:0]  disp_len;
  logic [7:0]  disp_len_inc;
  logic        str_en_r;
  logic        cursor_r;
  logic        done_r;
  logic        vis_now;
  logic        vis_p0;
  logic        frame_tick;
  logic        step;

  // Rising edge of "on the first blanking line": tracked even while paused so
  // re-enabling in the middle of that line does not fabricate a tick.
  assign vis_now      = (bus.vcnt == V_LINE);
  assign frame_tick   = vis_now & ~vis_p0;
  assign step         = frame_tick & bus.enable;
  assign disp_len_inc = disp_len + 8'd1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      fcnt     <= '0;
      bcnt     <= '0;
      disp_len <= '0;
      str_en_r <= 1'b0;
      cursor_r <= 1'b0;
      done_r   <= 1'b0;
      vis_p0   <= 1'b0;
    end else begin
      vis_p0 <= vis_now;
      done_r <= 1'b0;
      if (bus.start) begin
        state    <= TYPE;
        fcnt     <= '0;
        bcnt     <= '0;
        disp_len <= '0;
        str_en_r <= 1'b1;
        cursor_r <= 1'b1;
      end else if (step) begin
        case (state)
          IDLE: begin
          end
          TYPE: begin
            if (fcnt == CHAR_LAST) begin
              fcnt     <= '0;
              disp_len <= disp_len_inc;
              if (disp_len_inc == LEN_LAST) begin
                state    <= HOLD;
                bcnt     <= '0;
                cursor_r <= 1'b1;
              end
            end else begin
              fcnt <= fcnt + 10'd1;
            end
          end
          HOLD: begin
            if (fcnt == HOLD_LAST) begin
              done_r   <= 1'b1;
              fcnt     <= '0;
              bcnt     <= '0;
              cursor_r <= 1'b1;
              if (LOOP != 0) begin
                state    <= TYPE;
                disp_len <= '0;
              end else begin
                state <= SHOW;
              end
            end else begin
              fcnt <= fcnt + 10'd1;
              if (bcnt == BLINK_LAST) begin
                bcnt     <= '0;
                cursor_r <= ~cursor_r;
              end else begin
                bcnt <= bcnt + 10'd1;
              end
            end
          end
          SHOW: begin
            // Only the cursor keeps moving once the message is parked.
            if (bcnt == BLINK_LAST) begin
              bcnt     <= '0;
              cursor_r <= ~cursor_r;
            end else begin
              bcnt <= bcnt + 10'd1;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  assign bus.display_length = disp_len;
  assign bus.str_en         = str_en_r;
  assign bus.cursor_on      = cursor_r;
  assign bus.done           = done_r;

endmodule

// File: tb/tb_message_sequencer.sv
// Directed bench for message_sequencer: a looping and a non-looping instance share
// one stimulus stream; a vector table covers the main flow, hand sequences the corners.
module tb_message_sequencer;

  localparam int VV = 10;

  logic        clk;
  logic        rst_n;
  logic [10:0] vcnt;
  logic        start;
  logic        enable;

  int n_tests = 0;
  int n_fail  = 0;

  message_sequencer_if bus1 ();
  message_sequencer_if bus0 ();

  assign bus1.vcnt = vcnt;  assign bus1.start = start;  assign bus1.enable = enable;
  assign bus0.vcnt = vcnt;  assign bus0.start = start;  assign bus0.enable = enable;

  message_sequencer #(.LENGTH(3), .V_VISIBLE(VV), .CHAR_FRAMES(2), .HOLD_FRAMES(4),
                      .LOOP(1), .BLINK_FRAMES(2))
    dut_loop (.clk(clk), .rst_n(rst_n), .bus(bus1.slave));

  message_sequencer #(.LENGTH(3), .V_VISIBLE(VV), .CHAR_FRAMES(2), .HOLD_FRAMES(4),
                      .LOOP(0), .BLINK_FRAMES(2))
    dut_show (.clk(clk), .rst_n(rst_n), .bus(bus0.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation still running, expected finish");
    $fatal(1, "timeout");
  end

  typedef struct {
    bit       st;
    bit       en;
    bit       tk;
    bit [7:0] dl1;
    bit       cur1;
    bit       dn1;
    bit [7:0] dl0;
    bit       cur0;
    bit       dn0;
    bit       str;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(bit st, bit en, bit tk, int dl1, bit cur1, bit dn1,
                              int dl0, bit cur0, bit dn0, bit str);
    vec_t v;
    v.st = st; v.en = en; v.tk = tk;
    v.dl1 = 8'(dl1); v.cur1 = cur1; v.dn1 = dn1;
    v.dl0 = 8'(dl0); v.cur0 = cur0; v.dn0 = dn0;
    v.str = str;
    return v;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic chk_both(input string name, input int dl, input bit str,
                          input bit cur, input bit dn);
    chk({name, " loop.dl"},   int'(bus1.display_length), dl);
    chk({name, " loop.str"},  int'(bus1.str_en), int'(str));
    chk({name, " loop.cur"},  int'(bus1.cursor_on), int'(cur));
    chk({name, " loop.done"}, int'(bus1.done), int'(dn));
    chk({name, " show.dl"},   int'(bus0.display_length), dl);
    chk({name, " show.str"},  int'(bus0.str_en), int'(str));
    chk({name, " show.cur"},  int'(bus0.cursor_on), int'(cur));
    chk({name, " show.done"}, int'(bus0.done), int'(dn));
  endtask

  // One frame-sized step: a gap edge so the line flag clears, then one edge with
  // the requested inputs; outputs are left ready for sampling 1 time unit later.
  task automatic do_step(input bit st, input bit en, input bit tk);
    @(posedge clk);
    @(negedge clk);
    start  = st;
    enable = en;
    vcnt   = tk ? 11'(VV) : 11'd0;
    @(posedge clk);
    #1;
    start = 1'b0;
    vcnt  = 11'd0;
  endtask

  initial begin
    rst_n = 1'b0; vcnt = '0; start = 1'b0; enable = 1'b1;

    //            st en tk  dl1 c1 d1  dl0 c0 d0 str
    vecs.push_back(mk(0,1,0, 0,0,0, 0,0,0, 0));   // idle
    vecs.push_back(mk(0,1,1, 0,0,0, 0,0,0, 0));   // tick ignored in IDLE
    vecs.push_back(mk(1,1,0, 0,1,0, 0,1,0, 1));   // start
    vecs.push_back(mk(0,1,1, 0,1,0, 0,1,0, 1));   // t1
    vecs.push_back(mk(0,1,1, 1,1,0, 1,1,0, 1));   // t2
    vecs.push_back(mk(0,1,1, 1,1,0, 1,1,0, 1));   // t3
    vecs.push_back(mk(0,1,1, 2,1,0, 2,1,0, 1));   // t4
    vecs.push_back(mk(0,1,1, 2,1,0, 2,1,0, 1));   // t5
    vecs.push_back(mk(0,1,1, 3,1,0, 3,1,0, 1));   // t6 -> HOLD
    vecs.push_back(mk(0,1,1, 3,1,0, 3,1,0, 1));   // t7
    vecs.push_back(mk(0,1,1, 3,0,0, 3,0,0, 1));   // t8 blink
    vecs.push_back(mk(0,1,1, 3,0,0, 3,0,0, 1));   // t9
    vecs.push_back(mk(0,1,1, 0,1,1, 3,1,1, 1));   // t10 done
    vecs.push_back(mk(0,1,1, 0,1,0, 3,1,0, 1));   // t11
    vecs.push_back(mk(0,1,1, 1,1,0, 3,0,0, 1));   // t12
    vecs.push_back(mk(0,1,1, 1,1,0, 3,0,0, 1));   // t13
    vecs.push_back(mk(0,1,1, 2,1,0, 3,1,0, 1));   // t14
    vecs.push_back(mk(0,1,1, 2,1,0, 3,1,0, 1));   // t15
    vecs.push_back(mk(0,1,1, 3,1,0, 3,0,0, 1));   // t16
    vecs.push_back(mk(0,1,1, 3,1,0, 3,0,0, 1));   // t17
    vecs.push_back(mk(0,1,1, 3,0,0, 3,1,0, 1));   // t18
    vecs.push_back(mk(0,1,1, 3,0,0, 3,1,0, 1));   // t19
    vecs.push_back(mk(0,1,1, 0,1,1, 3,0,0, 1));   // t20 second done (loop only)
    vecs.push_back(mk(0,1,1, 0,1,0, 3,0,0, 1));   // t21
    vecs.push_back(mk(0,1,1, 1,1,0, 3,1,0, 1));   // t22
    for (int p = 0; p < 5; p++)
      vecs.push_back(mk(0,0,1, 1,1,0, 3,1,0, 1)); // paused frames
    vecs.push_back(mk(0,1,1, 1,1,0, 3,1,0, 1));   // t23 resume
    vecs.push_back(mk(0,1,1, 2,1,0, 3,0,0, 1));   // t24

    // Reset state, including an asynchronous check before any clock edge matters.
    #12;
    chk_both("reset", 0, 0, 0, 0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      do_step(vecs[i].st, vecs[i].en, vecs[i].tk);
      chk($sformatf("vec%0d loop.dl", i),   int'(bus1.display_length), int'(vecs[i].dl1));
      chk($sformatf("vec%0d loop.cur", i),  int'(bus1.cursor_on),      int'(vecs[i].cur1));
      chk($sformatf("vec%0d loop.done", i), int'(bus1.done),           int'(vecs[i].dn1));
      chk($sformatf("vec%0d loop.str", i),  int'(bus1.str_en),         int'(vecs[i].str));
      chk($sformatf("vec%0d show.dl", i),   int'(bus0.display_length), int'(vecs[i].dl0));
      chk($sformatf("vec%0d show.cur", i),  int'(bus0.cursor_on),      int'(vecs[i].cur0));
      chk($sformatf("vec%0d show.done", i), int'(bus0.done),           int'(vecs[i].dn0));
      chk($sformatf("vec%0d show.str", i),  int'(bus0.str_en),         int'(vecs[i].str));
    end

    // Restart coincident with a tick while holding: start wins, counters clear.
    do_step(1, 1, 0);
    for (int i = 0; i < 6; i++) do_step(0, 1, 1);
    chk_both("enter_hold", 3, 1, 1, 0);
    do_step(0, 1, 1);
    do_step(1, 1, 1);
    chk_both("restart_on_tick", 0, 1, 1, 0);
    do_step(0, 1, 1);
    chk_both("restart_fcnt0", 0, 1, 1, 0);
    do_step(0, 1, 1);
    chk_both("restart_first_char", 1, 1, 1, 0);

    // Line counter parked on the blanking line for 3 clocks yields a single tick.
    @(posedge clk);
    @(negedge clk);
    vcnt = 11'(VV);
    repeat (3) @(posedge clk);
    #1;
    vcnt = 11'd0;
    chk_both("held_vcnt_one_tick", 1, 1, 1, 0);
    do_step(0, 1, 1);
    chk_both("after_held_tick", 2, 1, 1, 0);

    // Re-enabling while still on the blanking line must not count a frame.
    @(posedge clk);
    @(negedge clk);
    enable = 1'b0;
    vcnt   = 11'(VV);
    @(posedge clk);
    #1;
    enable = 1'b1;
    @(posedge clk);
    #1;
    vcnt = 11'd0;
    chk_both("resume_mid_frame", 2, 1, 1, 0);
    do_step(0, 1, 1);
    chk_both("resume_next_tick", 2, 1, 1, 0);
    do_step(0, 1, 1);
    chk_both("reenter_hold", 3, 1, 1, 0);
    do_step(0, 1, 1);
    do_step(0, 1, 1);
    do_step(0, 1, 1);
    chk_both("hold_before_reset", 3, 1, 0, 0);

    // Asynchronous reset between clock edges, one tick short of done.
    #2;
    rst_n = 1'b0;
    #1;
    chk_both("async_reset", 0, 0, 0, 0);
    @(negedge clk);
    rst_n = 1'b1;
    do_step(0, 1, 1);
    chk_both("post_reset_tick", 0, 0, 0, 0);
    do_step(0, 1, 1);
    chk_both("post_reset_idle", 0, 0, 0, 0);
    do_step(1, 1, 0);
    chk_both("post_reset_start", 0, 1, 1, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/message_sequencer.md
MESSAGE_SEQUENCER -- requirements
Module: message_sequencer

Interface
REQ-001 SHALL have parameter LENGTH, default 12: characters in the message, 1..255.
REQ-002 SHALL have parameter V_VISIBLE, default 480: first non-visible line number on vcnt.
REQ-003 SHALL have parameter CHAR_FRAMES, default 15: frames per revealed character, 1..1023.
REQ-004 SHALL have parameter HOLD_FRAMES, default 180: frames the full message is held before done, 1..1023.
REQ-005 SHALL have parameter LOOP, default 1: 1 = restart typing after hold, 0 = keep showing the full message.
REQ-006 SHALL have parameter BLINK_FRAMES, default 16: cursor half-period in frames during HOLD/SHOW, 1..1023.
REQ-007 SHALL have port clk, input, 1: pixel clock, rising edge.
REQ-008 SHALL have port rst_n, input, 1: asynchronous active-low reset.
REQ-009 SHALL have port vcnt, input, 11: line counter from the timing generator.
REQ-010 SHALL have port start, input, 1: single-cycle pulse that starts or restarts the sequence.
REQ-011 SHALL have port enable, input, 1: level; low pauses reveal/hold counting.
REQ-012 SHALL have port display_length, output, 8: registered count of visible characters, fed to the string renderer.
REQ-013 SHALL have port str_en, output, 1: registered enable for the string renderer.
REQ-014 SHALL have port cursor_on, output, 1: registered cursor-visible flag.
REQ-015 SHALL have port done, output, 1: registered single-cycle pulse at end of hold.

Function
REQ-016 SHALL generate internal frame_tick for exactly one clk when vcnt==V_VISIBLE and the registered previous-cycle value of (vcnt==V_VISIBLE) is 0, so updates occur only in vertical blanking.
REQ-017 SHALL implement states IDLE, TYPE, HOLD, SHOW with a 10-bit frame counter fcnt.
REQ-018 SHALL in IDLE hold display_length=0, str_en=0, cursor_on=0.
REQ-019 SHALL on start in any state enter TYPE next cycle with display_length=0, fcnt=0, cursor_on=1; start has priority over every other event in the same cycle.
REQ-020 SHALL in TYPE, on frame_tick with enable=1: if fcnt==CHAR_FRAMES-1 then fcnt<=0 and display_length<=display_length+1, else fcnt<=fcnt+1.
REQ-021 SHALL in TYPE, when the increment makes display_length equal LENGTH, enter HOLD in the same update with fcnt=0, cursor_on=1; display_length never exceeds LENGTH.
REQ-022 SHALL in HOLD, on frame_tick with enable=1: if fcnt==HOLD_FRAMES-1 then pulse done for one cycle, fcnt<=0, and go to TYPE with display_length=0 (LOOP=1) or to SHOW (LOOP=0), else fcnt<=fcnt+1.
REQ-023 SHALL in SHOW hold display_length=LENGTH and str_en=1 until start or reset; SHOW ignores frame_tick except for cursor blink.
REQ-024 SHALL in HOLD and SHOW toggle cursor_on on every BLINK_FRAMES-th enabled frame_tick, using a separate 10-bit blink counter cleared on state entry; cursor_on=1 constantly in TYPE.
REQ-025 SHALL assert str_en=1 in TYPE, HOLD, SHOW.
REQ-026 SHALL freeze all counters and outputs while enable=0; frame_tick is still tracked so resuming mid-frame produces no spurious tick.
REQ-027 SHALL ignore frame_tick in IDLE; a start and a frame_tick in the same cycle count only the start.

Reset
REQ-028 SHALL on rst_n=0 asynchronously force state=IDLE, display_length=0, str_en=0, cursor_on=0, done=0, fcnt=0, blink counter=0, previous-vcnt flag=0.
REQ-029 SHALL reset mid-sequence abandon it with no done pulse; operation resumes only on a new start after rst_n deasserts.

Verification
REQ-030 SHALL cover basic reveal: LENGTH=3, CHAR_FRAMES=2, HOLD_FRAMES=4, LOOP=1, start then 6 frames -> display_length 0,0,1,1,2,2->3, HOLD entered at 6th tick, str_en=1 throughout.
REQ-031 SHALL cover hold/loop: continue 4 frames -> done high exactly one clk at 4th tick, display_length=0, state TYPE.
REQ-032 SHALL cover LOOP=0: same run -> after done, display_length stays 3, str_en=1, cursor_on toggles every BLINK_FRAMES=2 ticks for 10 frames, no further done.
REQ-033 SHALL cover pause: enable=0 for 5 frames mid-TYPE at display_length=1 -> display_length and fcnt unchanged; enable=1 -> reveal resumes on the next tick.
REQ-034 SHALL cover restart and tick boundary: start coincident with frame_tick during HOLD -> TYPE, display_length=0, fcnt=0 and no increment; vcnt held at V_VISIBLE 3 cycles -> one tick only.
REQ-035 SHALL cover reset: rst_n low during HOLD, asynchronously between clk edges -> all outputs 0 immediately, no done pulse.
